// File: rtl/sprite_fetch_if.sv
// Scan-side and ROM-side signals of one sprite_fetch instance.
// The DUT uses the slave modport; the timing generator, ROM and compositor use the master side.
interface sprite_fetch_if #(
  parameter int CORDW  = 10,
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  // No valid/ready: one scan position is accepted every clock. pix_valid only
  // qualifies pix as an opaque sprite pixel; nothing can stall the pipe.
  logic              frame;
  logic              line;
  logic [CORDW-1:0]  sx;
  logic [CORDW-1:0]  sy;
  logic [CORDW-1:0]  spr_x;
  logic [CORDW-1:0]  spr_y;
  logic              mirror;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] pix;
  logic              pix_valid;

  modport master (
    output frame, line, sx, sy, spr_x, spr_y, mirror, rom_data,
    input  rom_addr, pix, pix_valid
  );

  modport slave (
    input  frame, line, sx, sy, spr_x, spr_y, mirror, rom_data,
    output rom_addr, pix, pix_valid
  );
endinterface

// File: rtl/sprite_fetch.sv
// Sprite read engine: scan position -> ROM address -> opaque pixel, fixed 3-cycle latency.
// Optional horizontal flip is enabled by defining SPRITE_MIRROR_EN.
module sprite_fetch #(
  parameter int                SPR_W  = 83,
  parameter int                SPR_H  = 90,
  parameter int                ADDR_W = 13,
  parameter int                DATA_W = 8,
  parameter int                CORDW  = 10,
  parameter logic [DATA_W-1:0] TRANSP = 8'h00
) (
  input  logic          clk_pix,
  input  logic          rst_pix,
  sprite_fetch_if.slave bus
);

  // One extra bit keeps py+SPR_H and px+SPR_W from wrapping at the screen edge.
  localparam int                CW       = CORDW + 1;
  localparam logic [CW-1:0]     W_EXT    = CW'(SPR_W);
  localparam logic [CW-1:0]     H_EXT    = CW'(SPR_H);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SPR_W);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'((SPR_H - 1) * SPR_W);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(SPR_W - 1);

  logic [CORDW-1:0]  r_px;
  logic [CORDW-1:0]  r_py;
  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_hit_d1;
  logic              r_hit_d2;
  logic [DATA_W-1:0] r_pix;
  logic              r_pix_valid;

  logic [CW-1:0]     w_sx;
  logic [CW-1:0]     w_sy;
  logic [CW-1:0]     w_px;
  logic [CW-1:0]     w_py;
  logic [CW-1:0]     w_py_row;
  logic [CW-1:0]     w_dx;
  logic              w_hit;
  logic              w_row_first;
  logic              w_row_inside;
  logic [ADDR_W-1:0] w_col_fwd;
  logic [ADDR_W-1:0] w_col;

  assign w_sx = {1'b0, bus.sx};
  assign w_sy = {1'b0, bus.sy};
  assign w_px = {1'b0, r_px};
  assign w_py = {1'b0, r_py};

  // A line strobe coinciding with frame must compare against the position being latched now.
  assign w_py_row     = bus.frame ? {1'b0, bus.spr_y} : w_py;
  assign w_row_first  = (w_sy == w_py_row);
  assign w_row_inside = (w_sy > w_py_row) && (w_sy < (w_py_row + H_EXT));

  assign w_hit = (w_sx >= w_px) && (w_sx < (w_px + W_EXT)) &&
                 (w_sy >= w_py) && (w_sy < (w_py + H_EXT));

  assign w_dx      = w_sx - w_px;
  assign w_col_fwd = ADDR_W'(w_dx);

`ifdef SPRITE_MIRROR_EN
  logic r_mir;

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_mir <= 1'b0;
    end else if (bus.frame) begin
      r_mir <= bus.mirror;
    end
  end

  assign w_col = r_mir ? (COL_LAST - w_col_fwd) : w_col_fwd;
`else
  assign w_col = w_col_fwd;
`endif

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_px        <= '0;
      r_py        <= '0;
      r_row_base  <= '0;
      r_rom_addr  <= '0;
      r_hit_d1    <= 1'b0;
      r_hit_d2    <= 1'b0;
      r_pix       <= '0;
      r_pix_valid <= 1'b0;
    end else begin
      if (bus.frame) begin
        r_px <= bus.spr_x;
        r_py <= bus.spr_y;
      end

      // Row base steps by one sprite row per scanned line; the cap keeps a
      // skipped-line scan from ever pointing past the last row.
      if (bus.line) begin
        if (w_row_first) begin
          r_row_base <= '0;
        end else if (w_row_inside && (r_row_base != ROW_LAST)) begin
          r_row_base <= r_row_base + ROW_STEP;
        end
      end

      if (w_hit) begin
        r_rom_addr <= r_row_base + w_col;
      end

      r_hit_d1    <= w_hit;
      r_hit_d2    <= r_hit_d1;
      r_pix       <= r_hit_d2 ? bus.rom_data : '0;
      r_pix_valid <= r_hit_d2 && (bus.rom_data != TRANSP);
    end
  end

  assign bus.rom_addr  = r_rom_addr;
  assign bus.pix       = r_pix;
  assign bus.pix_valid = r_pix_valid;

endmodule
